// File: rtl/vid_meter_pkg.sv
// Shared types and constants for the video frame meter.
package vid_meter_pkg;

    localparam int CHK_W = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/vid_edge_det.sv
// Rising-edge detector: registers the pin once and compares it against a
// one-cycle-delayed copy. The pulse is high in the cycle after the pin rises.
module vid_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;
    logic prev_q;

    // Input register plus delayed copy used for the 0->1 compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q    <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            d_q    <= d_i;
            prev_q <= d_q;
        end
    end

    assign rise_o = d_q & ~prev_q;

endmodule

// File: rtl/vid_frame_meter.sv
// Measures line/frame timing and a pixel checksum of an incoming video
// stream, commits the results on every frame edge and flags mismatches
// against expected timing.
module vid_frame_meter
    import vid_meter_pkg::*;
#(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hs,
    input  logic                vs,
    input  logic                vld,
    input  logic [3*PW-1:0]     rgb,
    input  logic [H_BITS-1:0]   exp_h_total,
    input  logic [H_BITS-1:0]   exp_h_active,
    input  logic [V_BITS-1:0]   exp_v_total,
    input  logic [V_BITS-1:0]   exp_v_active,
    input  logic                clr_err,
    output logic [H_BITS-1:0]   meas_h_total,
    output logic [H_BITS-1:0]   meas_h_active,
    output logic [V_BITS-1:0]   meas_v_total,
    output logic [V_BITS-1:0]   meas_v_active,
    output logic [CHK_W-1:0]    checksum,
    output logic                meas_valid,
    output logic                err_h_total,
    output logic                err_h_active,
    output logic                err_v_total,
    output logic                err_v_active,
    output logic                locked
);

    localparam logic [H_BITS-1:0] H_ZERO = {H_BITS{1'b0}};
    localparam logic [V_BITS-1:0] V_ZERO = {V_BITS{1'b0}};
    localparam logic [H_BITS-1:0] H_ONE  = {{(H_BITS-1){1'b0}}, 1'b1};
    localparam logic [V_BITS-1:0] V_ONE  = {{(V_BITS-1){1'b0}}, 1'b1};
    localparam logic [CHK_W-1:0]  C_ZERO = {CHK_W{1'b0}};

    function automatic logic [H_BITS-1:0] sat_inc_h(input logic [H_BITS-1:0] v);
        return (&v) ? v : v + H_ONE;
    endfunction

    function automatic logic [V_BITS-1:0] sat_inc_v(input logic [V_BITS-1:0] v);
        return (&v) ? v : v + V_ONE;
    endfunction

    logic              line_edge_s;
    logic              frame_edge_s;
    logic              vld_q;
    logic [3*PW-1:0]   rgb_q;
    logic [CHK_W-1:0]  pix_sum_s;

    state_e            state_q,   state_d;
    logic [H_BITS-1:0] hcnt_q,    hcnt_d;     // clocks in current line
    logic [H_BITS-1:0] hact_q,    hact_d;     // vld cycles in current line
    logic [H_BITS-1:0] htot_q,    htot_d;     // last closed line, total
    logic [H_BITS-1:0] hlat_q,    hlat_d;     // last closed line, active
    logic [V_BITS-1:0] vcnt_q,    vcnt_d;     // closed lines in frame
    logic [V_BITS-1:0] vact_q,    vact_d;     // closed active lines in frame
    logic [CHK_W-1:0]  csum_q,    csum_d;

    logic [H_BITS-1:0] m_ht_q,    m_ht_d;
    logic [H_BITS-1:0] m_ha_q,    m_ha_d;
    logic [V_BITS-1:0] m_vt_q,    m_vt_d;
    logic [V_BITS-1:0] m_va_q,    m_va_d;
    logic [CHK_W-1:0]  chk_q,     chk_d;
    logic              mvalid_q,  mvalid_d;
    logic [3:0]        err_q,     err_d;      // {h_total, h_active, v_total, v_active}
    logic              locked_q,  locked_d;

    // Frame values as seen at a frame edge, folding in a coincident line edge.
    logic [H_BITS-1:0] fr_ht_s;
    logic [H_BITS-1:0] fr_ha_s;
    logic [V_BITS-1:0] fr_vt_s;
    logic [V_BITS-1:0] fr_va_s;
    logic [3:0]        mism_s;

    vid_edge_det u_hs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (hs),
        .rise_o (line_edge_s)
    );

    vid_edge_det u_vs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (vs),
        .rise_o (frame_edge_s)
    );

    assign pix_sum_s = CHK_W'(rgb_q[3*PW-1:2*PW]) + CHK_W'(rgb_q[2*PW-1:PW])
                     + CHK_W'(rgb_q[PW-1:0]);

    assign fr_ht_s = line_edge_s ? hcnt_q : htot_q;
    assign fr_ha_s = line_edge_s ? hact_q : hlat_q;
    assign fr_vt_s = line_edge_s ? sat_inc_v(vcnt_q) : vcnt_q;
    assign fr_va_s = (line_edge_s && (hact_q != H_ZERO)) ? sat_inc_v(vact_q) : vact_q;
    assign mism_s  = {fr_ht_s != exp_h_total, fr_ha_s != exp_h_active,
                      fr_vt_s != exp_v_total, fr_va_s != exp_v_active};

    // Next-state logic: counters, commit and state transitions.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        hact_d   = hact_q;
        htot_d   = htot_q;
        hlat_d   = hlat_q;
        vcnt_d   = vcnt_q;
        vact_d   = vact_q;
        csum_d   = csum_q;
        m_ht_d   = m_ht_q;
        m_ha_d   = m_ha_q;
        m_vt_d   = m_vt_q;
        m_va_d   = m_va_q;
        chk_d    = chk_q;
        mvalid_d = 1'b0;
        err_d    = clr_err ? 4'b0000 : err_q;
        case (state_q)
            SEARCH: begin
                if (frame_edge_s) begin
                    state_d = MEASURE;
                    hcnt_d  = H_ONE;
                    hact_d  = vld_q ? H_ONE : H_ZERO;
                    htot_d  = H_ZERO;
                    hlat_d  = H_ZERO;
                    vcnt_d  = V_ZERO;
                    vact_d  = V_ZERO;
                    csum_d  = vld_q ? pix_sum_s : C_ZERO;
                end else begin
                    state_d = SEARCH;
                end
            end
            MEASURE, LOCKED: begin
                if (line_edge_s) begin
                    htot_d = hcnt_q;
                    hlat_d = hact_q;
                    hcnt_d = H_ONE;
                    hact_d = vld_q ? H_ONE : H_ZERO;
                    vcnt_d = fr_vt_s;
                    vact_d = fr_va_s;
                end else begin
                    hcnt_d = sat_inc_h(hcnt_q);
                    hact_d = vld_q ? sat_inc_h(hact_q) : hact_q;
                end
                csum_d = vld_q ? csum_q + pix_sum_s : csum_q;
                if (frame_edge_s) begin
                    m_ht_d   = fr_ht_s;
                    m_ha_d   = fr_ha_s;
                    m_vt_d   = fr_vt_s;
                    m_va_d   = fr_va_s;
                    chk_d    = csum_q;
                    mvalid_d = 1'b1;
                    err_d    = err_d | mism_s;
                    state_d  = (mism_s == 4'b0000) ? LOCKED : MEASURE;
                    vcnt_d   = V_ZERO;
                    vact_d   = V_ZERO;
                    csum_d   = vld_q ? pix_sum_s : C_ZERO;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // State, counter, input and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            vld_q    <= 1'b0;
            rgb_q    <= {(3*PW){1'b0}};
            hcnt_q   <= H_ZERO;
            hact_q   <= H_ZERO;
            htot_q   <= H_ZERO;
            hlat_q   <= H_ZERO;
            vcnt_q   <= V_ZERO;
            vact_q   <= V_ZERO;
            csum_q   <= C_ZERO;
            m_ht_q   <= H_ZERO;
            m_ha_q   <= H_ZERO;
            m_vt_q   <= V_ZERO;
            m_va_q   <= V_ZERO;
            chk_q    <= C_ZERO;
            mvalid_q <= 1'b0;
            err_q    <= 4'b0000;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_q    <= vld;
            rgb_q    <= rgb;
            hcnt_q   <= hcnt_d;
            hact_q   <= hact_d;
            htot_q   <= htot_d;
            hlat_q   <= hlat_d;
            vcnt_q   <= vcnt_d;
            vact_q   <= vact_d;
            csum_q   <= csum_d;
            m_ht_q   <= m_ht_d;
            m_ha_q   <= m_ha_d;
            m_vt_q   <= m_vt_d;
            m_va_q   <= m_va_d;
            chk_q    <= chk_d;
            mvalid_q <= mvalid_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign meas_h_total  = m_ht_q;
    assign meas_h_active = m_ha_q;
    assign meas_v_total  = m_vt_q;
    assign meas_v_active = m_va_q;
    assign checksum      = chk_q;
    assign meas_valid    = mvalid_q;
    assign err_h_total   = err_q[3];
    assign err_h_active  = err_q[2];
    assign err_v_total   = err_q[1];
    assign err_v_active  = err_q[0];
    assign locked        = locked_q;

endmodule

// File: doc/vid_frame_meter.md
VID_FRAME_METER -- requirements
Module: vid_frame_meter

Interface
REQ-001 Parameters SHALL be: PW, default 8, pixel component width; H_BITS, default 12, horizontal counter width; V_BITS, default 12, vertical counter width.
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 hs, vs, vld  input  1 each  registered sync/valid outputs of the upstream pattern generator.
REQ-005 rgb  input  3*PW  pixel; components are [3*PW-1:2*PW], [2*PW-1:PW] and [PW-1:0].
REQ-006 exp_h_total, exp_h_active  input  H_BITS each  expected clocks per line and vld cycles per line.
REQ-007 exp_v_total, exp_v_active  input  V_BITS each  expected lines per frame and active lines per frame.
REQ-008 clr_err  input  1  clears the sticky error flags.
REQ-009 meas_h_total, meas_h_active  output  H_BITS each  last committed frame measurements.
REQ-010 meas_v_total, meas_v_active  output  V_BITS each  last committed frame measurements.
REQ-011 checksum  output  16  last committed frame pixel checksum.
REQ-012 meas_valid  output  1  one-cycle pulse when the meas_* and checksum outputs update.
REQ-013 err_h_total, err_h_active, err_v_total, err_v_active  output  1 each  sticky mismatch flags.
REQ-014 locked  output  1  high while state is LOCKED.

Function
REQ-015 hs, vs, vld and rgb SHALL be registered once on input; all further logic SHALL use the registered copies.
REQ-016 A line edge SHALL be a 0->1 transition of registered hs; a frame edge SHALL be a 0->1 transition of registered vs.
REQ-017 The line clock counter SHALL count cycles between consecutive line edges; the cycle carrying the edge SHALL count as 1 of the new line.
REQ-018 The line vld counter SHALL count registered vld cycles within the current line.
REQ-019 At each line edge: h_total and h_active SHALL latch from the closing line, the line count SHALL increment, and the active-line count SHALL increment if the closing line had h_active>0.
REQ-020 All counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-021 Checksum SHALL accumulate R+G+B (zero-extended, modulo 2^16) on each vld cycle of the frame.
REQ-022 If line and frame edges coincide, the closing line SHALL be included in the committed frame before the frame counters clear.
REQ-023 The state machine SHALL have three states: SEARCH (after reset; ignores data), MEASURE and LOCKED.
REQ-024 State transitions SHALL be: SEARCH->MEASURE on the first frame edge, which clears all counters; in MEASURE or LOCKED, each frame edge commits.
REQ-025 A commit SHALL update the meas_* outputs and checksum, pulse meas_valid, and compare the four measurements against the exp_* inputs.
REQ-026 After a commit, the next state SHALL be LOCKED if all four measurements match, otherwise MEASURE.
REQ-027 Latency: meas_valid SHALL assert exactly 2 cycles after the cycle in which vs rises at the input pin.
REQ-028 A mismatch at commit SHALL set the corresponding err_* flag; flags SHALL hold until clr_err.
REQ-029 If clr_err and a new mismatch occur in the same cycle, the flag SHALL be set (set wins).
REQ-030 Mismatch checking SHALL NOT occur in SEARCH.

Reset
REQ-031 While rst_n=0 at a clock edge, state SHALL become SEARCH and all counters, input registers and outputs SHALL be 0.
REQ-032 Reset mid-frame SHALL discard the partial frame; no meas_valid SHALL occur until two frame edges after release.

Structure
REQ-033 Package vid_meter_pkg SHALL hold the state enum (SEARCH, MEASURE, LOCKED) and the constant CHK_W=16.
REQ-034 One sub-module, vid_edge_det (registered rising-edge detector), SHALL be instantiated for hs and vs.

Verification
REQ-035 Stimulus: 3 frames with h_total=20, h_active=12, v_total=10, v_active=6, exp_* equal. Response: meas_valid on frame edges 2 and 3 only, locked=1 after the first commit, no err_* set.
REQ-036 Stimulus: as REQ-035 with exp_h_active=11. Response: err_h_active=1 and stays set, locked=0; after clr_err pulse the flag returns to 1 at the next commit.
REQ-037 Stimulus: constant rgb=0x010203, 72 vld cycles per frame. Response: checksum=432.
REQ-038 Stimulus: hs and vs rise in the same cycle. Response: meas_v_total=10, not 9.
REQ-039 Stimulus: hs held low for 5000 cycles. Response: meas_h_total=4095 (saturated).
REQ-040 Stimulus: rst_n=0 for 1 cycle mid-frame. Response: all outputs 0, state SEARCH, first meas_valid after the second following frame edge.
